kbd_scan_decoder: RTL and testbench

- Consumes PS/2 scan-code bytes from the ps2_keyboard FIFO interface (ready / nextdata_n / overflow) and decodes make, break, E0 and F0 sequences.
- Tracks the currently held key, converts it to ASCII, and counts distinct key presses.
- Drives six seg outputs directly: scan code, ASCII and press count in hex.
- Sits between ps2_keyboard and the NVBoard seven-segment pins in top.

---
 rtl/kbd_scan_decoder_pkg.sv | 43 ++++
 rtl/kbd_scan_decoder_if.sv | 14 +
 rtl/kbd_scan_decoder_hex7seg.sv | 33 +++
 rtl/kbd_scan_decoder.sv | 145 ++++++++++++++
 tb/tb_kbd_scan_decoder.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kbd_scan_decoder_pkg.sv
// Shared types, scan-code constants and the scan-code to ASCII lookup.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_PROC
  } state_t;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  // Pattern of hex digit "0"; seg4/seg5 show this while the count is zero.
  localparam logic [7:0] SEG_ZERO  = 8'h03;

  // Set-2 make code to lowercase ASCII; upper=1 shifts letters to uppercase.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic upper);
    logic [7:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20;
      default: a = 8'h00;
    endcase
    if (upper && (a >= 8'h61) && (a <= 8'h7A)) a = a - 8'h20;
    return a;
  endfunction

endpackage

// File: rtl/kbd_scan_decoder_if.sv
// PS/2 keyboard FIFO link: head byte, non-empty, overflow, and active-low pop.
// Latency: n/a (wires only).
// Backpressure: consumer pops with nextdata_n; producer holds the byte until popped.
interface kbd_scan_decoder_if;
  logic [7:0] ps2_byte;
  logic       ps2_ready;
  logic       ps2_overflow;
  logic       nextdata_n;

  // FIFO side (ps2_keyboard)
  modport master (output ps2_byte, output ps2_ready, output ps2_overflow, input nextdata_n);
  // Decoder side
  modport slave  (input ps2_byte, input ps2_ready, input ps2_overflow, output nextdata_n);
endinterface

// File: rtl/kbd_scan_decoder_hex7seg.sv
// One hex nibble to an active-low seven-segment pattern (bit7=a .. bit1=g, bit0=dp off).
// Latency: combinational.
// Backpressure: none.
module hex7seg (
  input  logic [3:0] nib,
  output logic [7:0] seg
);

  // Segment pattern per nibble value
  always_comb begin
    seg = 8'hFF;
    case (nib)
      4'h0: seg = 8'h03;
      4'h1: seg = 8'h9F;
      4'h2: seg = 8'h25;
      4'h3: seg = 8'h0D;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h49;
      4'h6: seg = 8'h41;
      4'h7: seg = 8'h1F;
      4'h8: seg = 8'h01;
      4'h9: seg = 8'h09;
      4'hA: seg = 8'h11;
      4'hB: seg = 8'hC1;
      4'hC: seg = 8'h63;
      4'hD: seg = 8'h85;
      4'hE: seg = 8'h61;
      4'hF: seg = 8'h71;
      default: seg = 8'hFF;
    endcase
  end

endmodule

// File: rtl/kbd_scan_decoder.sv
// PS/2 scan-code decoder: make/break/E0/F0 tracking, ASCII, press count, six hex digits.
// Latency: 3 cycles per byte (IDLE latch, POP strobe, PROC decode); segments one cycle later.
// Backpressure: pops only when ps2_ready; one byte in flight. Optional macro KBD_SHIFT_EN.
module kbd_scan_decoder
  import kbd_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input  logic                clk,
  input  logic                resetn,
  kbd_scan_decoder_if.slave   ps2,
  output logic                key_down,
  output logic [7:0]          scan_code,
  output logic [7:0]          ascii,
  output logic [COUNT_W-1:0]  press_count,
  output logic                ovf_seen,
  output logic [7:0]          seg0,
  output logic [7:0]          seg1,
  output logic [7:0]          seg2,
  output logic [7:0]          seg3,
  output logic [7:0]          seg4,
  output logic [7:0]          seg5
);

  state_t state_q, state_d;
  logic [7:0] byte_r;
  logic       brk_q, ext_q;
  logic       nextdata_q;
  logic       upper;
  logic [7:0] hx0, hx1, hx2, hx3, hx4, hx5;

`ifdef KBD_SHIFT_EN
  logic shift_q;
  logic is_shift;
  assign is_shift = (byte_r == SC_LSHIFT) || (byte_r == SC_RSHIFT);
  assign upper    = shift_q;
`else
  assign upper    = 1'b0;
`endif

  assign ps2.nextdata_n = nextdata_q;

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: one byte walks IDLE -> POP -> PROC -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ps2.ps2_ready) state_d = ST_POP;
      ST_POP:  state_d = ST_PROC;
      ST_PROC: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pop strobe is registered off the next state so it is low exactly while in POP
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) nextdata_q <= 1'b1;
    else         nextdata_q <= (state_d != ST_POP);
  end

  // Capture the FIFO head when leaving IDLE; later ready changes are irrelevant
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                   byte_r <= 8'h00;
    else if ((state_q == ST_IDLE) && ps2.ps2_ready) byte_r <= ps2.ps2_byte;
  end

  // Decode the latched byte once, in PROC
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      key_down    <= 1'b0;
      scan_code   <= 8'h00;
      ascii       <= 8'h00;
      press_count <= '0;
`ifdef KBD_SHIFT_EN
      shift_q     <= 1'b0;
`endif
    end else if (state_q == ST_PROC) begin
      if (byte_r == SC_EXT) begin
        ext_q <= 1'b1;
      end else if (byte_r == SC_BREAK) begin
        brk_q <= 1'b1;
`ifdef KBD_SHIFT_EN
      end else if (is_shift) begin
        // Shift is a modifier only: it never becomes the held key
        shift_q <= ~brk_q;
        brk_q   <= 1'b0;
        ext_q   <= 1'b0;
`endif
      end else if (brk_q) begin
        if (key_down && (byte_r == scan_code)) key_down <= 1'b0;
        brk_q <= 1'b0;
        ext_q <= 1'b0;
      end else begin
        // Same code while held is typematic repeat and leaves everything alone
        if (!(key_down && (byte_r == scan_code))) begin
          key_down    <= 1'b1;
          scan_code   <= byte_r;
          ascii       <= ext_q ? 8'h00 : scan_to_ascii(byte_r, upper);
          press_count <= press_count + COUNT_W'(1);
        end
        ext_q <= 1'b0;
      end
    end
  end

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ovf_seen <= 1'b0;
    else         ovf_seen <= ovf_seen | ps2.ps2_overflow;
  end

  hex7seg u_hx0 (.nib(scan_code[3:0]),   .seg(hx0));
  hex7seg u_hx1 (.nib(scan_code[7:4]),   .seg(hx1));
  hex7seg u_hx2 (.nib(ascii[3:0]),       .seg(hx2));
  hex7seg u_hx3 (.nib(ascii[7:4]),       .seg(hx3));
  hex7seg u_hx4 (.nib(press_count[3:0]), .seg(hx4));
  hex7seg u_hx5 (.nib(press_count[7:4]), .seg(hx5));

  // Register the display; key digits blank while no key is held
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seg0 <= SEG_BLANK;
      seg1 <= SEG_BLANK;
      seg2 <= SEG_BLANK;
      seg3 <= SEG_BLANK;
      seg4 <= SEG_ZERO;
      seg5 <= SEG_ZERO;
    end else begin
      seg0 <= key_down ? hx0 : SEG_BLANK;
      seg1 <= key_down ? hx1 : SEG_BLANK;
      seg2 <= key_down ? hx2 : SEG_BLANK;
      seg3 <= key_down ? hx3 : SEG_BLANK;
      seg4 <= hx4;
      seg5 <= hx5;
    end
  end

endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Directed bench for kbd_scan_decoder with a key-event model and per-cycle compare.
// Latency: n/a.
// Backpressure: n/a.
module tb_kbd_scan_decoder;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  kbd_scan_decoder_if ps2 ();

  logic       key_down, ovf_seen;
  logic [7:0] scan_code, ascii, press_count;
  logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5;

  kbd_scan_decoder #(.COUNT_W(8)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ps2        (ps2),
    .key_down   (key_down),
    .scan_code  (scan_code),
    .ascii      (ascii),
    .press_count(press_count),
    .ovf_seen   (ovf_seen),
    .seg0       (seg0),
    .seg1       (seg1),
    .seg2       (seg2),
    .seg3       (seg3),
    .seg4       (seg4),
    .seg5       (seg5)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Which segments light for each hex digit, written as letters a..g
  string seg_tbl [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                          "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [7:0] segpat(input logic [3:0] n);
    logic [7:0] p;
    string s;
    int k;
    p = 8'hFF;
    s = seg_tbl[n];
    for (int i = 0; i < s.len(); i++) begin
      k = int'(s[i]) - 97;
      p[7-k] = 1'b0;
    end
    return p;
  endfunction

  // Key-event model
  logic [7:0] amap [256];
  logic       m_kd, m_brk, m_ext, m_shift, m_ovf;
  logic [7:0] m_scan, m_ascii, m_count;
  logic       settled;

  task automatic init_map();
    string letters;
    string digits;
    logic [7:0] lc [26];
    logic [7:0] dc [10];
    letters = "abcdefghijklmnopqrstuvwxyz";
    digits  = "0123456789";
    lc = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
           8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    dc = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    for (int i = 0; i < 256; i++) amap[i] = 8'h00;
    for (int i = 0; i < 26; i++) amap[lc[i]] = letters[i];
    for (int i = 0; i < 10; i++) amap[dc[i]] = digits[i];
    amap[8'h29] = 8'h20;
  endtask

  task automatic model_reset();
    m_kd = 0; m_brk = 0; m_ext = 0; m_shift = 0; m_ovf = 0;
    m_scan = 0; m_ascii = 0; m_count = 0;
  endtask

  function automatic logic [7:0] char_of(input logic [7:0] b);
    logic [7:0] c;
    c = amap[b];
    if (m_shift && c >= "a" && c <= "z") c = c - 8'd32;
    return c;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
`ifdef KBD_SHIFT_EN
    else if (b == 8'h12 || b == 8'h59) begin
      m_shift = !m_brk; m_brk = 0; m_ext = 0;
    end
`endif
    else if (m_brk) begin
      if (b == m_scan) m_kd = 0;
      m_brk = 0; m_ext = 0;
    end else begin
      if (!(m_kd && b == m_scan)) begin
        m_kd    = 1;
        m_scan  = b;
        m_ascii = m_ext ? 8'h00 : char_of(b);
        m_count = m_count + 8'd1;
      end
      m_ext = 0;
    end
  endtask

  // Compare every settled cycle against the model
  always @(negedge clk) begin
    if (settled) begin
      chk("nextdata_n_idle", ps2.nextdata_n, 1'b1);
      chk("key_down", key_down, m_kd);
      chk("scan_code", scan_code, m_scan);
      chk("ascii", ascii, m_ascii);
      chk("press_count", press_count, m_count);
      chk("ovf_seen", ovf_seen, m_ovf);
      chk("seg0", seg0, m_kd ? segpat(m_scan[3:0]) : 8'hFF);
      chk("seg1", seg1, m_kd ? segpat(m_scan[7:4]) : 8'hFF);
      chk("seg2", seg2, m_kd ? segpat(m_ascii[3:0]) : 8'hFF);
      chk("seg3", seg3, m_kd ? segpat(m_ascii[7:4]) : 8'hFF);
      chk("seg4", seg4, segpat(m_count[3:0]));
      chk("seg5", seg5, segpat(m_count[7:4]));
    end
  end

  // Present one byte, wait for the pop, and let outputs settle
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    settled = 0;
    ps2.ps2_byte  = b;
    ps2.ps2_ready = 1'b1;
    while (ps2.nextdata_n !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ps2.ps2_ready = 1'b0;
    chk("pop_low", ps2.nextdata_n, 1'b0);
    if (ps2.nextdata_n === 1'b0) begin
      model_byte(b);
      @(negedge clk);
      chk("pop_one_cycle", ps2.nextdata_n, 1'b1);
      @(negedge clk);
      @(negedge clk);
    end
    settled = 1;
  endtask

  initial begin
    int pairs;
    settled = 0;
    init_map();
    model_reset();
    ps2.ps2_byte = 8'h00;
    ps2.ps2_ready = 1'b0;
    ps2.ps2_overflow = 1'b0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_nextdata_n", ps2.nextdata_n, 1'b1);
    chk("rst_key_down", key_down, 1'b0);
    chk("rst_count", press_count, 8'h00);
    chk("rst_seg0", seg0, 8'hFF);
    chk("rst_seg3", seg3, 8'hFF);
    chk("rst_seg4", seg4, 8'h03);
    chk("rst_seg5", seg5, 8'h03);
    resetn = 1'b1;
    @(negedge clk);
    settled = 1;
    @(negedge clk);

    // First make: 'a'
    send(8'h1C);
    chk("a_key_down", key_down, 1'b1);
    chk("a_scan", scan_code, 8'h1C);
    chk("a_ascii", ascii, 8'h61);
    chk("a_count", press_count, 8'h01);
    chk("a_seg1", seg1, 8'h9F);
    chk("a_seg0", seg0, 8'h63);
    chk("a_seg3", seg3, 8'h41);

    // Typematic repeats
    repeat (3) send(8'h1C);
    chk("rep_count", press_count, 8'h01);

    // Break
    send(8'hF0); send(8'h1C);
    chk("brk_key_down", key_down, 1'b0);
    chk("brk_seg2", seg2, 8'hFF);
    chk("brk_count", press_count, 8'h01);

    // Extended make and break
    send(8'hE0); send(8'h75);
    chk("ext_scan", scan_code, 8'h75);
    chk("ext_ascii", ascii, 8'h00);
    chk("ext_count", press_count, 8'h02);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_brk_key_down", key_down, 1'b0);

    // Break of a key that is not held
    send(8'h32);
    send(8'hF0); send(8'h1C);
    chk("stray_brk_key_down", key_down, 1'b1);
    send(8'hF0); send(8'h32);

`ifdef KBD_SHIFT_EN
    send(8'h12); send(8'h1C);
    chk("shift_ascii", ascii, 8'h41);
    chk("shift_count", press_count, 8'h04);
    chk("shift_scan", scan_code, 8'h1C);
    send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12);
    send(8'h1C);
    chk("unshift_ascii", ascii, 8'h61);
    chk("unshift_count", press_count, 8'h05);
    send(8'hF0); send(8'h1C);
`else
    send(8'h12);
    chk("lshift_plain_ascii", ascii, 8'h00);
    chk("lshift_plain_count", press_count, 8'h04);
    chk("lshift_plain_scan", scan_code, 8'h12);
    send(8'hF0); send(8'h12);
`endif

    // Wrap the press counter to zero with make/break pairs of '1'
    pairs = 256 - int'(m_count);
    for (int i = 0; i < pairs; i++) begin
      send(8'h16); send(8'hF0); send(8'h16);
    end
    chk("wrap_count", press_count, 8'h00);
    chk("wrap_seg4", seg4, 8'h03);
    chk("wrap_seg5", seg5, 8'h03);
    send(8'h16);
    chk("digit_ascii", ascii, 8'h31);
    send(8'hF0); send(8'h16);

    // Overflow pulse is sticky
    @(negedge clk);
    settled = 0;
    ps2.ps2_overflow = 1'b1;
    @(negedge clk);
    ps2.ps2_overflow = 1'b0;
    m_ovf = 1;
    settled = 1;
    chk("ovf_set", ovf_seen, 1'b1);
    repeat (5) @(negedge clk);
    chk("ovf_sticky", ovf_seen, 1'b1);

    // Reset after F0 discards the pending break
    send(8'hF0);
    settled = 0;
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    chk("mid_rst_ovf", ovf_seen, 1'b0);
    chk("mid_rst_count", press_count, 8'h00);
    resetn = 1'b1;
    @(negedge clk);
    settled = 1;
    send(8'h1C);
    chk("post_rst_key_down", key_down, 1'b1);
    chk("post_rst_count", press_count, 8'h01);
    repeat (3) @(negedge clk);

    settled = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
